// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, glyphs and BCD FSM states for the scan driver
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 24;
  localparam int BIN_W      = 20;
  localparam int SHIFT_N    = 20;

  // Largest value six decimal digits can show; larger inputs saturate here.
  localparam logic [BIN_W-1:0] DATA_MAX = 20'd999_999;

  // Active-low common-anode patterns, bit7 = DP, bits 6..0 = g..a.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DP_MASK   = 8'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } bcd_state_t;

  // Non-decimal nibbles cannot come out of the converter; they map to blank.
  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - display bundle from data_gen in, digit select and segments out
interface seg_scan_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (output data, point, sign, seg_en, input sel, seg);
  modport slave  (input data, point, sign, seg_en, output sel, seg);
endinterface

// File: rtl/seg_scan_bin2bcd.sv
// rtl/seg_scan_bin2bcd.sv - free-running sequential double-dabble binary to BCD converter
module bin2bcd
  import seg_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             valid
);

  localparam int          WORK_W    = BCD_W + BIN_W;
  localparam logic [4:0]  LAST_ITER = 5'(SHIFT_N - 1);

  bcd_state_t        state_q, state_d;
  logic [4:0]        iter_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] adj;

  // FSM state register; reset abandons any conversion in flight.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; the loop never waits, so conversion is continuous.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (iter_q == LAST_ITER) state_d = S_DONE;
      S_DONE: begin
        valid   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble that would overflow on the next shift.
  always_comb begin
    adj = work_q;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (work_q[BIN_W + 4*n +: 4] >= 4'd5)
        adj[BIN_W + 4*n +: 4] = work_q[BIN_W + 4*n +: 4] + 4'd3;
    end
  end

  // Datapath: latch the operand, shift 20 times, publish the BCD half.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      work_q <= '0;
      iter_q <= '0;
      bcd    <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          work_q <= {{BCD_W{1'b0}}, bin};
          iter_q <= '0;
        end
        S_SHIFT: begin
          work_q <= {adj[WORK_W-2:0], 1'b0};
          iter_q <= iter_q + 5'd1;
        end
        S_DONE:  bcd <= work_q[WORK_W-1:BIN_W];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - six-digit multiplexed seven-segment driver with blanking, DP and sign
module seg_scan
  import seg_pkg::*;
#(
  parameter int CNT_MAX = 49_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  seg_scan_if.slave  bus
);

  localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [BIN_W-1:0] bin_clamped;
  logic [BCD_W-1:0] bcd_q;
  logic             bcd_valid_unused;
  logic [2:0]       msd;
  logic [3:0]       cur_digit;
  logic [5:0]       sel_d;
  logic [7:0]       seg_d;

  assign bin_clamped = (bus.data > DATA_MAX) ? DATA_MAX : bus.data;

  // The display reads bcd continuously, so the conversion strobe is not needed here.
  bin2bcd u_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bin       (bin_clamped),
    .bcd       (bcd_q),
    .valid     (bcd_valid_unused)
  );

  // Most significant shown digit: highest nonzero digit or highest lit DP, at least 0.
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((bcd_q[4*i +: 4] != 4'd0) || bus.point[i]) msd = 3'(i);
    end
  end

  assign cur_digit = bcd_q[4*idx_q +: 4];

  // Dwell counter and digit index; they keep running while the display is off.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Content of the currently selected digit: glyph, minus in front of msd, or blank.
  always_comb begin
    sel_d = '0;
    seg_d = SEG_BLANK;
    if (bus.seg_en) begin
      sel_d = 6'b000001 << idx_q;
      if (idx_q <= msd) begin
        seg_d = digit_glyph(cur_digit);
        if (bus.point[idx_q]) seg_d = seg_d & DP_MASK;
      end else if (bus.sign && (msd < 3'd5) && (idx_q == msd + 3'd1)) begin
        seg_d = SEG_MINUS;
      end
    end
  end

  // sel and seg share one register stage so they can never disagree.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bus.sel <= '0;
      bus.seg <= SEG_BLANK;
    end else begin
      bus.sel <= sel_d;
      bus.seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan with a 10-cycle dwell
module tb_seg_scan;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] gl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_scan_if bus();

  seg_scan #(.CNT_MAX(9)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference display model: decimal digits by division, pushed digit0..digit5.
  task automatic model(input int value, input logic [5:0] pt, input logic sg);
    int v;
    int dig [6];
    int m;
    logic [7:0] s;
    v = (value > 999999) ? 999999 : value;
    for (int i = 0; i < 6; i++) begin
      dig[i] = v % 10;
      v = v / 10;
    end
    m = 0;
    for (int i = 0; i < 6; i++) if (dig[i] != 0 || pt[i]) m = i;
    for (int i = 0; i < 6; i++) begin
      if (i <= m) begin
        s = gl[dig[i]];
        if (pt[i]) s = s & 8'h7F;
      end else if (i == m + 1 && sg && m < 5) begin
        s = 8'hBF;
      end else begin
        s = 8'hFF;
      end
      exp_q.push_back(s);
    end
  endtask

  task automatic sync_frame(output bit found);
    logic [5:0] prev;
    found = 1'b0;
    prev  = bus.sel;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (bus.sel == 6'b000001 && prev != 6'b000001) found = 1'b1;
      else prev = bus.sel;
    end
  endtask

  task automatic check_frame(input string tag);
    bit found;
    logic [7:0] e;
    sync_frame(found);
    chk($sformatf("%s sync", tag), 32'(found), 32'd1);
    for (int d = 0; d < 6; d++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      chk($sformatf("%s sel%0d", tag, d), 32'(bus.sel), 32'(6'b000001 << d));
      chk($sformatf("%s seg%0d", tag, d), 32'(bus.seg), 32'(e));
      repeat (9) @(negedge clk);
      chk($sformatf("%s dwell%0d", tag, d), 32'(bus.sel), 32'(6'b000001 << d));
      @(negedge clk);
    end
    chk($sformatf("%s wrap", tag), 32'(bus.sel), 32'd1);
  endtask

  task automatic apply(input int value, input logic [5:0] pt, input logic sg);
    bus.data  = 20'(value);
    bus.point = pt;
    bus.sign  = sg;
    model(value, pt, sg);
    repeat (50) @(negedge clk);
  endtask

  initial begin
    bit found;
    logic [7:0] e0;
    rst_n      = 1'b0;
    bus.data   = '0;
    bus.point  = '0;
    bus.sign   = 1'b0;
    bus.seg_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset sel", 32'(bus.sel), 32'd0);
    chk("reset seg", 32'(bus.seg), 32'hFF);
    chk("reset bcd", 32'(dut.bcd_q), 32'd0);

    rst_n = 1'b1;
    apply(123456, 6'b000000, 1'b0);
    check_frame("n123456");

    apply(5, 6'b000000, 1'b1);
    check_frame("neg5");

    apply(0, 6'b000100, 1'b0);
    check_frame("zero_dp");

    apply(999999, 6'b000000, 1'b1);
    check_frame("max_sign");

    apply(20'hFFFFF, 6'b000000, 1'b1);
    check_frame("clamp");

    apply(123456, 6'b000000, 1'b0);
    e0 = exp_q[0];
    exp_q.delete();
    sync_frame(found);
    chk("en sync", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    bus.seg_en = 1'b0;
    @(negedge clk);
    chk("en off sel", 32'(bus.sel), 32'd0);
    chk("en off seg", 32'(bus.seg), 32'hFF);
    bus.seg_en = 1'b1;
    @(negedge clk);
    chk("en on sel", 32'(bus.sel), 32'd1);
    chk("en on seg", 32'(bus.seg), 32'(e0));
    repeat (4) @(negedge clk);
    chk("en dwell kept", 32'(bus.sel), 32'd1);
    @(negedge clk);
    chk("en advance", 32'(bus.sel), 32'd2);

    bus.data = 20'd654321;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dut.u_bcd.state_q == S_SHIFT) found = 1'b1;
    end
    chk("reach shift", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst sel", 32'(bus.sel), 32'd0);
    chk("midrst seg", 32'(bus.seg), 32'hFF);
    chk("midrst bcd", 32'(dut.bcd_q), 32'd0);
    chk("midrst fsm", 32'(dut.u_bcd.state_q), 32'(S_IDLE));
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 46 && !found; c++) begin
      @(negedge clk);
      if (dut.bcd_q == 24'h654321) found = 1'b1;
    end
    chk("post rst bcd", 32'(found), 32'd1);
    model(654321, 6'b000000, 1'b0);
    check_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
